// File: rtl/enigma_step_ctrl_if.sv
// Handshake bundle for the Enigma step controller:
// rotor config load, letter input and result output.
interface enigma_step_ctrl_if;
  logic       cfg_valid;
  logic [4:0] cfg_pos0;
  logic [4:0] cfg_pos1;
  logic [4:0] cfg_pos2;
  logic       cfg_ready;
  logic       in_valid;
  logic [4:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_char;
  logic       out_ready;

  modport master (
    output cfg_valid, cfg_pos0, cfg_pos1, cfg_pos2,
    output in_valid, in_char, out_ready,
    input  cfg_ready, in_ready, out_valid, out_char
  );

  modport slave (
    input  cfg_valid, cfg_pos0, cfg_pos1, cfg_pos2,
    input  in_valid, in_char, out_ready,
    output cfg_ready, in_ready, out_valid, out_char
  );
endinterface

// File: rtl/enigma_step_ctrl.sv
// Enigma rotor stepping and sequencing controller:
// notch/double-step advance, settle wait, result handshake.
module enigma_step_ctrl #(
  parameter int NOTCH0        = 16,
  parameter int NOTCH1        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  enigma_step_ctrl_if.slave  bus,
  output logic [4:0]         pos0,
  output logic [4:0]         pos1,
  output logic [4:0]         pos2,
  output logic [4:0]         dp_char,
  input  logic [4:0]         dp_result,
  output logic               err,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_OUTPUT
  } state_t;

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SETTLE_CYCLES - 1);
  localparam logic [4:0] N0 = 5'(NOTCH0);
  localparam logic [4:0] N1 = 5'(NOTCH1);

  state_t        r_state;
  logic [4:0]    r_pos0;
  logic [4:0]    r_pos1;
  logic [4:0]    r_pos2;
  logic [4:0]    r_dp_char;
  logic [4:0]    r_out_char;
  logic          r_out_valid;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  logic w_idle;
  logic w_cfg_ok;
  logic w_in_ok;

  // Mod-26 advance that never forms a value above 25.
  function automatic logic [4:0] inc26(
    input logic [4:0] p
  );
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_cfg_ok = (bus.cfg_pos0 <= 5'd25) &&
                    (bus.cfg_pos1 <= 5'd25) &&
                    (bus.cfg_pos2 <= 5'd25);
  assign w_in_ok  = (bus.in_char <= 5'd25);

  assign bus.cfg_ready = w_idle;
  assign bus.in_ready  = w_idle && !bus.cfg_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.out_char  = r_out_char;

  assign pos0    = r_pos0;
  assign pos1    = r_pos1;
  assign pos2    = r_pos2;
  assign dp_char = r_dp_char;
  assign err     = r_err;
  assign busy    = !w_idle;

  // Sequencer: accept, step on old positions, settle,
  // capture the chain result, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pos0      <= '0;
      r_pos1      <= '0;
      r_pos2      <= '0;
      r_dp_char   <= '0;
      r_out_char  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            if (w_cfg_ok) begin
              r_pos0 <= bus.cfg_pos0;
              r_pos1 <= bus.cfg_pos1;
              r_pos2 <= bus.cfg_pos2;
            end else begin
              r_err <= 1'b1;
            end
          end else if (bus.in_valid) begin
            if (w_in_ok) begin
              r_dp_char <= bus.in_char;
              r_state   <= S_STEP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_STEP: begin
          r_pos0 <= inc26(r_pos0);
          if (r_pos1 == N1) begin
            r_pos1 <= inc26(r_pos1);
            r_pos2 <= inc26(r_pos2);
          end else if (r_pos0 == N0) begin
            r_pos1 <= inc26(r_pos1);
          end
          r_cnt   <= '0;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_out_char  <= dp_result;
            r_out_valid <= 1'b1;
            r_state     <= S_OUTPUT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Random + directed bench for enigma_step_ctrl with a
// transaction-level rotor model and a settling chain stub.
module tb_enigma_step_ctrl;

  localparam int N0 = 16;
  localparam int N1 = 4;
  localparam int S  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] pos0, pos1, pos2, dp_char;
  logic [4:0] dp_result = '0;
  logic       err, busy;
  bit         chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  enigma_step_ctrl_if bus();

  enigma_step_ctrl #(
    .NOTCH0(N0), .NOTCH1(N1), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .pos0(pos0), .pos1(pos1), .pos2(pos2),
    .dp_char(dp_char), .dp_result(dp_result),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string nm, input int act, input int exp
  );
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Stand-in for the rotor/reflector chain.
  function automatic int chain(
    input int a, input int b, input int c, input int ch
  );
    return (ch + a + 3 * b + 7 * c) % 26;
  endfunction

  // Chain stub: output is garbage until its inputs have
  // been stable long enough, so early capture shows up.
  logic [19:0] prev = '0;
  int          stab = 0;
  initial forever begin
    logic [19:0] cur;
    int v;
    @(negedge clk);
    cur = {pos0, pos1, pos2, dp_char};
    if (cur != prev) stab = 0;
    else if (stab < 100) stab++;
    prev = cur;
    v = chain(pos0, pos1, pos2, dp_char);
    if (stab >= S - 1) dp_result = 5'(v);
    else dp_result = 5'(v) ^ 5'($urandom_range(1, 31));
  end

  // Transaction-level model: m_t counts cycles since a
  // letter was accepted (-1 when idle).
  int m_t = -1;
  int m_p0 = 0, m_p1 = 0, m_p2 = 0;
  int m_dp = 0, m_oc = 0;
  bit m_ov = 0, m_err = 0;

  initial forever begin
    int o0, o1;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_t = -1; m_p0 = 0; m_p1 = 0; m_p2 = 0;
      m_dp = 0; m_oc = 0; m_ov = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (m_t < 0) begin
        if (bus.cfg_valid) begin
          if (bus.cfg_pos0 <= 25 && bus.cfg_pos1 <= 25
              && bus.cfg_pos2 <= 25) begin
            m_p0 = bus.cfg_pos0;
            m_p1 = bus.cfg_pos1;
            m_p2 = bus.cfg_pos2;
          end else m_err = 1;
        end else if (bus.in_valid) begin
          if (bus.in_char <= 25) begin
            m_dp = bus.in_char;
            m_t = 0;
          end else m_err = 1;
        end
      end else if (m_ov) begin
        if (bus.out_ready) begin
          m_ov = 0;
          m_t = -1;
        end
      end else begin
        m_t++;
        if (m_t == 1) begin
          o0 = m_p0; o1 = m_p1;
          m_p0 = (o0 + 1) % 26;
          if (o1 == N1) begin
            m_p1 = (o1 + 1) % 26;
            m_p2 = (m_p2 + 1) % 26;
          end else if (o0 == N0) begin
            m_p1 = (o1 + 1) % 26;
          end
        end
        if (m_t == 1 + S) begin
          m_ov = 1;
          m_oc = chain(m_p0, m_p1, m_p2, m_dp);
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("pos0", pos0, m_p0);
      check("pos1", pos1, m_p1);
      check("pos2", pos2, m_p2);
      check("dp_char", dp_char, m_dp);
      check("out_valid", bus.out_valid, m_ov);
      check("out_char", bus.out_char, m_oc);
      check("err", err, m_err);
      check("busy", busy, (m_t >= 0) ? 1 : 0);
      check("cfg_ready", bus.cfg_ready,
            (m_t < 0) ? 1 : 0);
      check("in_ready", bus.in_ready,
            (m_t < 0 && !bus.cfg_valid) ? 1 : 0);
    end
  end

  // All stimulus tasks start and end at posedge+2.
  task automatic cfg(input int a, input int b, input int c);
    bus.cfg_valid = 1'b1;
    bus.cfg_pos0 = 5'(a);
    bus.cfg_pos1 = 5'(b);
    bus.cfg_pos2 = 5'(c);
    @(posedge clk); #2;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send(input int ch, input bit to_idle);
    int lat;
    bus.in_valid = 1'b1;
    bus.in_char = 5'(ch);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #2;
      lat++;
    end
    check("latency", lat, 1 + S);
    if (to_idle) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic chk_pos(
    input string nm, input int a, input int b, input int c
  );
    check({nm, ".pos0"}, pos0, a);
    check({nm, ".pos1"}, pos1, b);
    check({nm, ".pos2"}, pos2, c);
  endtask

  initial begin
    int oc, p0, ovs;
    bus.cfg_valid = 1'b0;
    bus.cfg_pos0 = '0;
    bus.cfg_pos1 = '0;
    bus.cfg_pos2 = '0;
    bus.in_valid = 1'b0;
    bus.in_char = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst.pos0", pos0, 0);
    check("rst.dp_char", dp_char, 0);
    check("rst.out_char", bus.out_char, 0);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.err", err, 0);
    check("rst.busy", busy, 0);
    check("rst.cfg_ready", bus.cfg_ready, 1);
    check("rst.in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    send(0, 1'b1);
    chk_pos("first", 1, 0, 0);
    check("first.out_char", bus.out_char, 1);
    check("model.oc", m_oc, 1);

    cfg(16, 0, 0);
    chk_pos("cfg16", 16, 0, 0);
    send(0, 1'b1);
    chk_pos("notch", 17, 1, 0);

    cfg(15, 0, 0);
    send(0, 1'b1);
    chk_pos("pre_notch", 16, 0, 0);
    send(0, 1'b1);
    chk_pos("notch2", 17, 1, 0);

    cfg(16, 3, 0);
    send(0, 1'b1);
    chk_pos("dbl1", 17, 4, 0);
    send(0, 1'b1);
    chk_pos("dbl2", 18, 5, 1);
    check("model.p2", m_p2, 1);

    cfg(25, 25, 25);
    send(0, 1'b1);
    chk_pos("wrap", 0, 25, 25);

    bus.out_ready = 1'b0;
    send(7, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_char = 5'd9;
    oc = bus.out_char;
    p0 = pos0;
    check("bp.out_char", oc, 24);
    repeat (10) begin
      @(posedge clk); #2;
      check("bp.hold", bus.out_char, oc);
      check("bp.in_ready", bus.in_ready, 0);
      check("bp.pos0", pos0, p0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp.busy", busy, 0);
    chk_pos("bp", 1, 25, 25);

    bus.in_valid = 1'b1;
    bus.in_char = 5'd26;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    check("badchar.err", err, 1);
    check("badchar.busy", busy, 0);
    @(posedge clk); #2;
    check("badchar.err_off", err, 0);
    chk_pos("badchar", 1, 25, 25);

    cfg(5, 30, 5);
    check("badcfg.err", err, 1);
    @(posedge clk); #2;
    check("badcfg.err_off", err, 0);
    chk_pos("badcfg", 1, 25, 25);

    bus.cfg_valid = 1'b1;
    bus.cfg_pos0 = 5'd3;
    bus.cfg_pos1 = 5'd4;
    bus.cfg_pos2 = 5'd5;
    bus.in_valid = 1'b1;
    bus.in_char = 5'd2;
    #1 check("both.in_ready", bus.in_ready, 0);
    @(posedge clk); #2;
    bus.cfg_valid = 1'b0;
    bus.in_valid = 1'b0;
    check("both.busy", busy, 0);
    chk_pos("both", 3, 4, 5);
    send(2, 1'b1);
    chk_pos("both_dbl", 4, 5, 6);

    bus.in_valid = 1'b1;
    bus.in_char = 5'd3;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst.pos0", pos0, 0);
    check("arst.busy", busy, 0);
    check("arst.dp_char", dp_char, 0);
    check("arst.out_valid", bus.out_valid, 0);
    #2 rst_n = 1'b1;
    ovs = 0;
    repeat (6) begin
      @(posedge clk); #2;
      if (bus.out_valid) ovs++;
    end
    check("arst.no_out", ovs, 0);
    send(0, 1'b1);
    chk_pos("arst_after", 1, 0, 0);

    repeat (500) begin
      bus.cfg_valid = ($urandom_range(0, 9) == 0);
      bus.cfg_pos0 = 5'($urandom_range(0, 25));
      bus.cfg_pos1 = 5'($urandom_range(0, 25));
      bus.cfg_pos2 = 5'($urandom_range(0, 25));
      if ($urandom_range(0, 9) == 0)
        bus.cfg_pos1 = 5'($urandom_range(26, 31));
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_char = 5'($urandom_range(0, 25));
      if ($urandom_range(0, 9) == 0)
        bus.in_char = 5'($urandom_range(26, 31));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0)
        bus.cfg_pos1 = 5'(N1);
      @(posedge clk); #2;
    end
    bus.cfg_valid = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
